cpu_decode_queue: RTL and testbench

//  Buffered, parametrised decode stage between fetch and issue. Accepts up to

---
 rtl/cpu_decode_queue.sv | 153 +++++++++++++++
 tb/tb_cpu_decode_queue.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_decode_queue.sv
// Decode queue: FETCH_W-wide enqueue into a DEPTH FIFO, one decoded head per cycle out.
// Define CPU_DECQ_NOP_SQUASH_EN to drop nops at enqueue (out_is_nop then tied 0).
module cpu_decode_queue #(
  parameter int FETCH_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*FETCH_W-1:0]        in_inst,
  input  logic [31:0]                  in_pc,
  input  logic [FETCH_W-1:0]           in_mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc,
  output logic [12:0]                  out_class,
  output logic                         out_has_imm,
  output logic                         out_has_jump,
  output logic                         out_could_branch,
  output logic                         out_is_nop,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [12:0] cls;
    logic        has_imm;
    logic        has_jump;
    logic        could_branch;
    logic        is_nop;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] i);
    logic [5:0] op;
    logic [5:0] fn;
    logic sp, ld, st, ar, ai, sh, mm, mx;
    logic jr, ja, bc, be, c0, ex;
    dec_t d;
    op = i[31:26];
    fn = i[5:0];
    sp = (op == 6'd0);
    ld = (op[5:3] == 3'b100);
    st = (op[5:3] == 3'b101);
    ai = (op[5:3] == 3'b001);
    ar = sp && (fn[5:4] == 2'b10);
    sh = sp && (fn[5:3] == 3'b000);
    mm = sp && (fn[5:3] == 3'b010);
    mx = sp && (fn[5:3] == 3'b011);
    jr = sp && (fn[5:1] == 5'b00100);
    ex = sp && (fn[5:1] == 5'b00110);
    ja = (op[5:1] == 5'b00001);
    bc = (op == 6'b000001);
    be = (op[5:2] == 4'b0001);
    c0 = (op == 6'b010000);
    d.cls = {ld, st, ar, ai, sh, mm, mx, jr, ja, bc, be, c0, ex};
    d.has_imm = ld | st | ai | bc | be;
    d.has_jump = ja;
    d.could_branch = ld | st | jr | ja | bc | be | ex | c0
                   | (ar && (fn == 6'h20 || fn == 6'h22))
                   | (op == 6'h08);
    d.is_nop = ((ar | sh) && (i[15:11] == 5'd0))
             | (ai && (i[20:16] == 5'd0));
    return d;
  endfunction

  logic [31:0]        mem_inst [DEPTH];
  logic [31:0]        mem_pc   [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [OW-1:0]      occ;
  logic [OW-1:0]      push_cnt;
  logic [FETCH_W-1:0] keep;
  logic [AW-1:0]      wr_addr [FETCH_W];
  logic               accept, pop;
  dec_t               hd;

  assign occupancy = occ;
  assign in_ready  = (OW'(DEPTH) - occ) >= OW'(FETCH_W);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = !flush && (occ != '0) && (!out_valid || out_ready);
  assign hd        = decode(mem_inst[rd_ptr]);

  // Select surviving slots and pack them into consecutive FIFO addresses
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
`ifdef CPU_DECQ_NOP_SQUASH_EN
      keep[i] = in_mask[i] && !decode(in_inst[32*i +: 32]).is_nop;
`else
      keep[i] = in_mask[i];
`endif
      wr_addr[i] = wr_ptr + push_cnt[AW-1:0];
      if (keep[i]) push_cnt = push_cnt + 1'b1;
    end
  end

  // FIFO pointers and occupancy; flush and reset empty the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + push_cnt[AW-1:0];
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + (accept ? push_cnt : '0) - OW'(pop);
    end
  end

  // FIFO storage writes for each kept slot
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (accept && keep[i]) begin
        mem_inst[wr_addr[i]] <= in_inst[32*i +: 32];
        mem_pc[wr_addr[i]]   <= in_pc + 32'(4*i);
      end
    end
  end

  // Registered output stage loading the decoded FIFO head
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid        <= 1'b0;
      out_inst         <= '0;
      out_pc           <= '0;
      out_class        <= '0;
      out_has_imm      <= 1'b0;
      out_has_jump     <= 1'b0;
      out_could_branch <= 1'b0;
      out_is_nop       <= 1'b0;
    end else if (pop) begin
      out_valid        <= 1'b1;
      out_inst         <= mem_inst[rd_ptr];
      out_pc           <= mem_pc[rd_ptr];
      out_class        <= hd.cls;
      out_has_imm      <= hd.has_imm;
      out_has_jump     <= hd.has_jump;
      out_could_branch <= hd.could_branch;
`ifdef CPU_DECQ_NOP_SQUASH_EN
      out_is_nop       <= 1'b0;
`else
      out_is_nop       <= hd.is_nop;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_decode_queue.sv
// Bench for cpu_decode_queue: queue-level model checked every cycle
// plus literal pins on key directed scenarios.
module tb_cpu_decode_queue;

  localparam int FW = 2;
  localparam int DP = 8;

  logic        clk = 0;
  logic        rst, flush, in_valid, in_ready, out_ready;
  logic [63:0] in_inst;
  logic [31:0] in_pc;
  logic [1:0]  in_mask;
  logic        out_valid;
  logic [31:0] out_inst, out_pc;
  logic [12:0] out_class;
  logic        out_has_imm, out_has_jump, out_could_branch, out_is_nop;
  logic [3:0]  occupancy;

  int vecs = 0;
  int errs = 0;

  cpu_decode_queue #(.FETCH_W(FW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_class(out_class),
    .out_has_imm(out_has_imm), .out_has_jump(out_has_jump),
    .out_could_branch(out_could_branch), .out_is_nop(out_is_nop),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

`ifdef CPU_DECQ_NOP_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  // {class[12:0], has_imm, has_jump, could_branch, is_nop}
  function automatic logic [16:0] mdec(input logic [31:0] i);
    logic [5:0] op, fn;
    logic [12:0] c;
    logic imm, jmp, cb, nop;
    op = i[31:26];
    fn = i[5:0];
    c = '0;
    if (op == 0) begin
      if (fn >= 6'h20 && fn <= 6'h2F) c[10] = 1;
      else if (fn <= 6'h07) c[8] = 1;
      else if (fn >= 6'h10 && fn <= 6'h17) c[7] = 1;
      else if (fn >= 6'h18 && fn <= 6'h1F) c[6] = 1;
      else if (fn == 6'h08 || fn == 6'h09) c[5] = 1;
      else if (fn == 6'h0C || fn == 6'h0D) c[0] = 1;
    end
    else if (op == 1) c[3] = 1;
    else if (op == 2 || op == 3) c[4] = 1;
    else if (op >= 4 && op <= 7) c[2] = 1;
    else if (op >= 8 && op <= 15) c[9] = 1;
    else if (op == 16) c[1] = 1;
    else if (op >= 32 && op <= 39) c[12] = 1;
    else if (op >= 40 && op <= 47) c[11] = 1;
    imm = c[12] | c[11] | c[9] | c[3] | c[2];
    jmp = c[4];
    cb  = c[12] | c[11] | c[5] | c[4] | c[3] | c[2] | c[0] | c[1]
        | (c[10] && (fn == 6'h20 || fn == 6'h22)) | (op == 6'h08);
    nop = ((c[10] | c[8]) && i[15:11] == 0) | (c[9] && i[20:16] == 0);
    return {c, imm, jmp, cb, nop};
  endfunction

  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t q[$];
  bit          started = 0;
  bit          mv = 0;
  logic [31:0] mi = 0, mp = 0;
  logic [16:0] md = 0;

  // Model: state after each rising edge, from the inputs present then
  always @(posedge clk) begin
    if (rst) started = 1;
    if (rst || flush) begin
      q.delete();
      mv = 0; mi = 0; mp = 0; md = 0;
    end else begin
      bit rdy;
      ent_t e;
      rdy = (DP - q.size()) >= FW;
      if (q.size() > 0 && (!mv || out_ready)) begin
        e = q.pop_front();
        mv = 1; mi = e.inst; mp = e.pc; md = mdec(e.inst);
        if (SQ) md[0] = 0;
      end else if (out_ready) begin
        mv = 0;
      end
      if (in_valid && rdy) begin
        for (int s = 0; s < FW; s++) begin
          logic [31:0] w;
          w = in_inst[32*s +: 32];
          if (in_mask[s] && !(SQ && mdec(w)[0])) begin
            e.inst = w; e.pc = in_pc + 4*s;
            q.push_back(e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Compare process at the falling edge
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'((DP - q.size()) >= FW));
      chk("out_inst", out_inst, mi);
      chk("out_pc", out_pc, mp);
      chk("out_flags", 32'({out_class, out_has_imm, out_has_jump,
                            out_could_branch, out_is_nop}), 32'(md));
    end
  end

  task automatic cyc(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                     input logic [31:0] pc, input logic [1:0] m,
                     input logic ordy, input logic fl, input logic r);
    in_valid = v; in_inst = {i1, i0}; in_pc = pc; in_mask = m;
    out_ready = ordy; flush = fl; rst = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, ordy, 0, 0);
  endtask

  logic [31:0] mix [8] = '{32'h40000000, 32'h04010005, 32'h10220003,
                           32'h03E00008, 32'h0000000C, 32'h00430018,
                           32'hFC000000, 32'h20000005};

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_data", out_inst | out_pc, 0);

    cyc(1, 32'h8C220004, 32'h00430820, 32'h100, 2'b11, 1, 0, 0);
    idle(1, 1);
    chk("lw_valid", 32'(out_valid), 1);
    chk("lw_inst", out_inst, 32'h8C220004);
    chk("lw_pc", out_pc, 32'h100);
    chk("lw_class", 32'(out_class), 32'h1000);
    chk("lw_imm", 32'(out_has_imm), 1);
    idle(1, 1);
    chk("add_pc", out_pc, 32'h104);
    chk("add_class", 32'(out_class), 32'h0400);
    chk("add_cb", 32'(out_could_branch), 1);
    idle(1, 2);

    for (int k = 0; k < 20; k++) begin
      if (!in_ready) break;
      cyc(1, 32'h20210000 + 2*k, 32'h20210001 + 2*k, 32'h400 + 8*k, 2'b11, 0, 0, 0);
    end
    chk("fill_full", 32'(occupancy >= DP - 1), 1);
    chk("fill_ready", 32'(in_ready), 0);
    idle(0, 3);
    chk("fill_hold", out_pc, 32'h400);
    idle(1, 12);

    cyc(1, 32'h8C220004, 32'h08000040, 32'h200, 2'b10, 1, 0, 0);
    idle(1, 1);
    chk("j_pc", out_pc, 32'h204);
    chk("j_jump", 32'(out_has_jump), 1);
    chk("j_class", 32'(out_class), 32'h0010);
    idle(1, 2);

    for (int k = 0; k < 3; k++)
      cyc(1, 32'h20220000 + k, 32'h20230000 + k, 32'h500 + 8*k, 2'b11, 0, 0, 0);
    chk("pre_flush_occ", 32'(occupancy), 5);
    cyc(1, 32'h8C440000, 32'h8C450000, 32'h600, 2'b11, 1, 1, 0);
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_valid", 32'(out_valid), 0);
    idle(1, 4);

    cyc(1, 32'h0, 32'h0, 32'h300, 2'b01, 1, 0, 0);
`ifdef CPU_DECQ_NOP_SQUASH_EN
    chk("sq_occ", 32'(occupancy), 0);
    idle(1, 1);
    chk("sq_valid", 32'(out_valid), 0);
`else
    idle(1, 1);
    chk("nop_flag", 32'(out_is_nop), 1);
    chk("nop_class", 32'(out_class), 32'h0100);
`endif
    idle(1, 2);

    for (int k = 0; k < 4; k++)
      cyc(1, mix[2*k], mix[2*k+1], 32'h700 + 8*k, 2'b11, k[0], 0, 0);
    cyc(1, 32'h00001010, 32'h00430022, 32'h800, 2'b00, 1, 0, 0);
    cyc(1, 32'h00001010, 32'h00430022, 32'h800, 2'b11, 0, 0, 0);
    idle(1, 14);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
